// File: rtl/execute_stage.sv
// MIPS execute stage with the EX/MEM pipeline register.
// Operands are picked through the forwarding muxes and the ALU result is
// computed combinationally. Only registered values reach the outputs.
module execute_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [3:0]         i_alu_code,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [NB_REG-1:0]  i_shamt,
    input  logic               i_alu_src,
    input  logic               i_shift_src,
    input  logic [1:0]         i_fwd_a,
    input  logic [1:0]         i_fwd_b,
    input  logic [NB_DATA-1:0] i_mem_fwd_data,
    input  logic [NB_DATA-1:0] i_wb_fwd_data,
    input  logic [NB_REG-1:0]  i_rd_addr,
    input  logic               i_reg_write,
    input  logic               i_mem_read,
    input  logic               i_mem_write,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_alu_result,
    output logic               o_zero,
    output logic [NB_DATA-1:0] o_store_data,
    output logic [NB_REG-1:0]  o_rd_addr,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write
);

    logic [NB_DATA-1:0] op_a;
    logic [NB_DATA-1:0] op_bf;
    logic [NB_DATA-1:0] op_b;
    logic [NB_REG-1:0]  shamt;
    logic [NB_DATA-1:0] alu_result;

    // Forwarding selection; code 11 falls back to the register value.
    always_comb begin
        op_a = i_rs_data;
        case (i_fwd_a)
            2'b01:   op_a = i_mem_fwd_data;
            2'b10:   op_a = i_wb_fwd_data;
            default: op_a = i_rs_data;
        endcase
        op_bf = i_rt_data;
        case (i_fwd_b)
            2'b01:   op_bf = i_mem_fwd_data;
            2'b10:   op_bf = i_wb_fwd_data;
            default: op_bf = i_rt_data;
        endcase
        op_b  = i_alu_src ? i_imm : op_bf;
        shamt = i_shift_src ? op_a[NB_REG-1:0] : i_shamt;
    end

    // ALU; wraps modulo 2^NB_DATA, unused codes yield zero.
    always_comb begin
        alu_result = '0;
        case (i_alu_code)
            4'b0000: alu_result = op_b << shamt;
            4'b0001: alu_result = op_b >> shamt;
            4'b0010: alu_result = $signed(op_b) >>> shamt;
            4'b0011: alu_result = op_a + op_b;
            4'b0100: alu_result = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b0101: alu_result = op_a & op_b;
            4'b0110: alu_result = op_a | op_b;
            4'b0111: alu_result = op_a ^ op_b;
            4'b1000: alu_result = ~(op_a | op_b);
            4'b1001: alu_result = op_b << 16;
            4'b1010: alu_result = op_a - op_b;
            default: alu_result = '0;
        endcase
    end

    // EX/MEM register: flush beats stall beats load; an invalid load is a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_zero       <= 1'b0;
            o_store_data <= '0;
            o_rd_addr    <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
        end else if (i_flush || (!i_stall && !i_valid)) begin
            o_valid      <= 1'b0;
            o_alu_result <= '0;
            o_zero       <= 1'b0;
            o_store_data <= '0;
            o_rd_addr    <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
        end else if (!i_stall) begin
            o_valid      <= 1'b1;
            o_alu_result <= alu_result;
            o_zero       <= (alu_result == '0);
            o_store_data <= op_bf;
            o_rd_addr    <= i_rd_addr;
            o_reg_write  <= i_reg_write;
            o_mem_read   <= i_mem_read;
            o_mem_write  <= i_mem_write;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases plus randomized traffic against a
// behavioural model of the EX/MEM register contents.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_stall, i_flush, i_valid;
    logic [3:0]  i_alu_code;
    logic [31:0] i_rs_data, i_rt_data, i_imm;
    logic [4:0]  i_shamt;
    logic        i_alu_src, i_shift_src;
    logic [1:0]  i_fwd_a, i_fwd_b;
    logic [31:0] i_mem_fwd_data, i_wb_fwd_data;
    logic [4:0]  i_rd_addr;
    logic        i_reg_write, i_mem_read, i_mem_write;
    logic        o_valid;
    logic [31:0] o_alu_result;
    logic        o_zero;
    logic [31:0] o_store_data;
    logic [4:0]  o_rd_addr;
    logic        o_reg_write, o_mem_read, o_mem_write;

    int errors = 0;
    int checks = 0;

    // expected EX/MEM contents
    logic        e_valid, e_zero, e_rw, e_mr, e_mw;
    logic [31:0] e_res, e_store;
    logic [4:0]  e_rd;

    execute_stage #(.NB_DATA(32), .NB_REG(5)) dut (
        .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_alu_code(i_alu_code), .i_rs_data(i_rs_data),
        .i_rt_data(i_rt_data), .i_imm(i_imm), .i_shamt(i_shamt),
        .i_alu_src(i_alu_src), .i_shift_src(i_shift_src), .i_fwd_a(i_fwd_a),
        .i_fwd_b(i_fwd_b), .i_mem_fwd_data(i_mem_fwd_data),
        .i_wb_fwd_data(i_wb_fwd_data), .i_rd_addr(i_rd_addr),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .o_valid(o_valid),
        .o_alu_result(o_alu_result), .o_zero(o_zero),
        .o_store_data(o_store_data), .o_rd_addr(o_rd_addr),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'd1) return m;
        if (sel == 2'd2) return w;
        return r;
    endfunction

    // Arithmetic reference: shifts via powers of two, subtraction via two's complement.
    function automatic logic [31:0] model_alu(input logic [3:0] code, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sa);
        logic [63:0] wide;
        logic [63:0] pw;
        logic [31:0] nb;
        pw   = 64'd1 << sa;
        wide = 64'd0;
        case (code)
            4'd0:  wide = {32'd0, b} * pw;
            4'd1:  wide = {32'd0, b} / pw;
            4'd2:  begin
                       if (b[31]) begin
                           nb   = ~b;
                           wide = {32'd0, ~(32'({32'd0, nb} / pw))};
                       end else begin
                           wide = {32'd0, b} / pw;
                       end
                   end
            4'd3:  wide = {32'd0, a} + {32'd0, b};
            4'd4:  wide = (int'(a) < int'(b)) ? 64'd1 : 64'd0;
            4'd5:  wide = {32'd0, a & b};
            4'd6:  wide = {32'd0, a | b};
            4'd7:  wide = {32'd0, a ^ b};
            4'd8:  wide = {32'd0, ~(a | b)};
            4'd9:  wide = {32'd0, b} * 64'd65536;
            4'd10: wide = {32'd0, a} + {32'd0, ~b} + 64'd1;
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    task automatic model_clear();
        e_valid = 0; e_res = 0; e_zero = 0; e_store = 0;
        e_rd = 0; e_rw = 0; e_mr = 0; e_mw = 0;
    endtask

    task automatic model_edge();
        logic [31:0] a, bf, b;
        logic [4:0]  sa;
        if (i_flush || (!i_stall && !i_valid)) begin
            model_clear();
        end else if (!i_stall) begin
            a  = pick(i_fwd_a, i_rs_data, i_mem_fwd_data, i_wb_fwd_data);
            bf = pick(i_fwd_b, i_rt_data, i_mem_fwd_data, i_wb_fwd_data);
            b  = i_alu_src ? i_imm : bf;
            sa = i_shift_src ? a[4:0] : i_shamt;
            e_valid = 1;
            e_res   = model_alu(i_alu_code, a, b, sa);
            e_zero  = (e_res == 32'd0);
            e_store = bf;
            e_rd = i_rd_addr; e_rw = i_reg_write; e_mr = i_mem_read; e_mw = i_mem_write;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  32'(o_valid),     32'(e_valid));
        check({tag, ".result"}, o_alu_result,     e_res);
        check({tag, ".zero"},   32'(o_zero),      32'(e_zero));
        check({tag, ".store"},  o_store_data,     e_store);
        check({tag, ".rd"},     32'(o_rd_addr),   32'(e_rd));
        check({tag, ".rw"},     32'(o_reg_write), 32'(e_rw));
        check({tag, ".mr"},     32'(o_mem_read),  32'(e_mr));
        check({tag, ".mw"},     32'(o_mem_write), 32'(e_mw));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic set_op(input logic [3:0] code, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] imm, input logic [4:0] sh, input logic asrc,
                          input logic ssrc);
        @(negedge clk);
        i_valid = 1; i_stall = 0; i_flush = 0;
        i_alu_code = code; i_rs_data = rs; i_rt_data = rt; i_imm = imm;
        i_shamt = sh; i_alu_src = asrc; i_shift_src = ssrc;
        i_fwd_a = 0; i_fwd_b = 0; i_mem_fwd_data = 0; i_wb_fwd_data = 0;
        i_rd_addr = 5'd3; i_reg_write = 1; i_mem_read = 0; i_mem_write = 0;
    endtask

    initial begin
        rst_n = 0;
        i_stall = 0; i_flush = 0; i_valid = 0; i_alu_code = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_shamt = 0;
        i_alu_src = 0; i_shift_src = 0; i_fwd_a = 0; i_fwd_b = 0;
        i_mem_fwd_data = 0; i_wb_fwd_data = 0; i_rd_addr = 0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
        model_clear();
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        set_op(4'd3, 32'd5, 32'd7, 32'd0, 5'd0, 0, 0);
        step("add");
        check("add_const", o_alu_result, 32'd12);

        set_op(4'd2, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 0, 0);
        step("sra");
        check("sra_const", o_alu_result, 32'hF800_0000);
        set_op(4'd1, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 0, 0);
        step("srl");
        check("srl_const", o_alu_result, 32'h0800_0000);
        set_op(4'd0, 32'h23, 32'h0000_1001, 32'd0, 5'd0, 0, 1);
        step("sllv");
        check("sllv_const", o_alu_result, 32'h0000_8008);

        set_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 0, 0);
        step("slt");
        check("slt_const", o_alu_result, 32'd1);
        set_op(4'd10, 32'd9, 32'd9, 32'd0, 5'd0, 0, 0);
        step("sub");
        check("sub_zero", 32'(o_zero), 32'd1);
        set_op(4'd9, 32'd0, 32'd0, 32'h1234, 5'd0, 1, 0);
        step("lui");
        check("lui_const", o_alu_result, 32'h1234_0000);

        set_op(4'd3, 32'd1, 32'd2, 32'd0, 5'd0, 0, 0);
        i_fwd_a = 2'b01; i_mem_fwd_data = 32'd100;
        i_fwd_b = 2'b10; i_wb_fwd_data = 32'd20;
        step("fwd");
        check("fwd_const", o_alu_result, 32'd120);
        @(negedge clk);
        i_mem_write = 1; i_alu_src = 1; i_imm = 32'd4;
        step("fwd_sw");
        check("fwd_sw_res", o_alu_result, 32'd104);
        check("fwd_sw_store", o_store_data, 32'd20);

        set_op(4'd3, 32'd5, 32'd7, 32'd0, 5'd0, 0, 0);
        step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_stall = 1; i_rs_data = $urandom; i_alu_code = 4'($urandom);
            step("stall");
            check("stall_hold", o_alu_result, 32'd12);
        end
        @(negedge clk);
        i_flush = 1; i_mem_write = 1;
        step("stall_flush");
        check("flush_valid", 32'(o_valid), 32'd0);

        set_op(4'd7, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 5'd0, 0, 0);
        step("pre_rst");
        #3;
        rst_n = 0;
        #1;
        model_clear();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        rst_n = 1;
        step("rst_release");
        check("rst_release_valid", 32'(o_valid), 32'd1);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            i_valid = ($urandom_range(0, 7) != 0);
            i_stall = ($urandom_range(0, 5) == 0);
            i_flush = ($urandom_range(0, 11) == 0);
            i_alu_code = 4'($urandom);
            i_rs_data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            i_rt_data = ($urandom_range(0, 3) == 0) ? i_rs_data : $urandom;
            i_imm = $urandom; i_shamt = 5'($urandom);
            i_alu_src = 1'($urandom); i_shift_src = 1'($urandom);
            i_fwd_a = 2'($urandom); i_fwd_b = 2'($urandom);
            i_mem_fwd_data = $urandom; i_wb_fwd_data = $urandom;
            i_rd_addr = 5'($urandom); i_reg_write = 1'($urandom);
            i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- MIPS EX stage plus EX/MEM pipeline register. Sits directly downstream of the ALU control decoder.
- Consumes the decoder's 4-bit alu_code together with ID/EX operands, selects forwarded operands, and computes the ALU result.
- Registers the result and the memory/writeback controls into EX/MEM, with stall and flush support.
- The registered result is the mem-stage forwarding source for following instructions.

Parameters:
NB_DATA, 32, datapath width (operands, immediate, result)
NB_REG, 5, register address width and shift-amount width

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  hold the EX/MEM register.
- i_flush  in  1  load a bubble into EX/MEM.
- i_valid  in  1  ID/EX holds a real instruction.
- i_alu_code  in  4  operation code from the ALU control decoder.
- i_rs_data  in  NB_DATA  rs value from ID/EX.
- i_rt_data  in  NB_DATA  rt value from ID/EX.
- i_imm  in  NB_DATA  extended immediate.
- i_shamt  in  NB_REG  instr[10:6].
- i_alu_src  in  1  0: B = forwarded rt; 1: B = i_imm.
- i_shift_src  in  1  0: shift amount = i_shamt; 1: shift amount = forwarded rs[4:0] (variable shifts).
- i_fwd_a  in  2  forwarding select for the rs operand.
- i_fwd_b  in  2  forwarding select for the rt operand.
- i_mem_fwd_data  in  NB_DATA  EX/MEM result to forward.
- i_wb_fwd_data  in  NB_DATA  MEM/WB writeback data to forward.
- i_rd_addr  in  NB_REG  destination register.
- i_reg_write  in  1  writeback control.
- i_mem_read  in  1  memory control.
- i_mem_write  in  1  memory control.
- o_valid  out  1  EX/MEM holds a real instruction.
- o_alu_result  out  NB_DATA  registered ALU result.
- o_zero  out  1  registered (result == 0).
- o_store_data  out  NB_DATA  registered forwarded rt value, taken before the alu_src mux.
- o_rd_addr  out  NB_REG  registered destination register.
- o_reg_write  out  1  registered writeback control.
- o_mem_read  out  1  registered memory control.
- o_mem_write  out  1  registered memory control.

Behaviour:
- Reset is asynchronous: rst_n low clears every output to 0 immediately and holds them there. o_valid is 0 after reset. First load happens on the first rising edge with rst_n high.
- Forwarding muxes are combinational:
  - 00: register data.
  - 01: i_mem_fwd_data.
  - 10: i_wb_fwd_data.
  - 11: treated as 00.
- A = forwarded rs. Bf = forwarded rt. B = i_alu_src ? i_imm : Bf. sa = i_shift_src ? A[4:0] : i_shamt.
- ALU operations by alu_code. All arithmetic is modulo 2^NB_DATA, with no overflow trap.
  - 0000: B << sa.
  - 0001: B >> sa (logical).
  - 0010: B >>> sa (arithmetic, sign-filled).
  - 0011: A + B.
  - 0100: signed A < B ? 1 : 0.
  - 0101: A & B.
  - 0110: A | B.
  - 0111: A ^ B.
  - 1000: ~(A | B).
  - 1001: B << 16 (lui).
  - 1010: A − B.
  - 1011–1111: result 0. Register controls load normally.
- EX/MEM register updates on the rising clk edge. Priority is flush > stall > load.
  - Flush: o_valid, o_reg_write, o_mem_read and o_mem_write go to 0. All data outputs go to 0.
  - Stall (no flush): every output holds its value.
  - Load with i_valid=1: all outputs take the computed values, o_valid=1.
  - Load with i_valid=0: same as flush (bubble).
- Latency is exactly 1 cycle from inputs to registered outputs. There is no combinational path from inputs to any output.
- o_zero is computed from the same result that is loaded into o_alu_result.
- If reset asserts mid-stall, the reset wins and the held state is discarded.

Test Plan:
- Reset, then i_valid=1, code 0011, rs=5, rt=7, alu_src=0, reg_write=1, rd=3 → one cycle later o_alu_result=12, o_zero=0, o_rd_addr=3, o_reg_write=1, o_valid=1.
- Code 0010, rt=0x80000000, shamt=4, shift_src=0 → 0xF8000000. Code 0001, same inputs → 0x08000000. Code 0000 with shift_src=1, rs=0x23 → rt<<3.
- Code 0100, rs=0xFFFFFFFF, rt=1 → 1. Code 1010, rs=rt=9 → result 0, o_zero=1. Code 1001, imm=0x1234, alu_src=1 → 0x12340000.
- fwd_a=01 with i_mem_fwd_data=100, fwd_b=10 with i_wb_fwd_data=20, code 0011 → 120. Same with mem_write=1, alu_src=1, imm=4 → result 104, o_store_data=20.
- Load result 12, then i_stall=1 for 3 cycles with changing inputs → outputs hold 12. Next assert i_stall and i_flush together → o_valid=0, o_mem_write=0, o_alu_result=0.
- Assert rst_n low asynchronously mid-cycle while o_valid=1 → all outputs 0 before the next clk edge. Outputs stay 0 until release. Load resumes on the first edge after release.
